fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the ARMv4 core front end. Drives the PC register's enable/load controls, issues one-outstanding instruction-memory requests at the current PC, and hands fetched words to decode through a single-entry valid/ready buffer. Handles branch redirects: loads the new PC, flushes buffered data and discards any in-flight response.

## Interface
- DATA_W, 32, instruction and address width; the PC is fixed at 32 bits.
- PERF_W, 32, width of the performance counters; used only with FETCH_CTRL_PERF_EN.

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_pc  in  32  current PC from the PC register
- o_pc_en  out  1  PC register update enable
- o_pc_load  out  1  selects o_pc_target as the next PC instead of PC+4
- o_pc_target  out  32  redirect target
- o_imem_req  out  1  memory request
- o_imem_addr  out  32  request address, word-aligned
- i_imem_ack  in  1  response valid; sampled only while o_imem_req=1
- i_imem_rdata  in  32  instruction word, valid with ack
- o_inst_valid  out  1  buffered instruction valid
- o_inst  out  32  buffered instruction
- o_inst_pc  out  32  address of o_inst
- i_inst_ready  in  1  decode accepts the buffer this cycle
- i_branch_valid  in  1  single-cycle redirect request
- i_branch_target  in  32  redirect address; bits [1:0] are ignored and forced to 0

## Operation
- States: IDLE, FETCH, DISCARD.
- IDLE:
  - entered on reset; all outputs are 0.
  - always moves to FETCH on the next clock.
- FETCH:
  - o_imem_req = !o_inst_valid || i_inst_ready. This is a combinational path from ready to req.
  - o_imem_addr = i_pc. The address stays stable until ack because the PC advances only on ack or branch.
- Ack in FETCH without a branch:
  - latch i_imem_rdata and i_pc into the buffer and set o_inst_valid.
  - pulse o_pc_en=1 with o_pc_load=0 (PC+4).
- Buffer drain: when o_inst_valid && i_inst_ready and no new ack arrives, clear o_inst_valid.
- Branch (i_branch_valid=1, any state except IDLE):
  - o_pc_en=1, o_pc_load=1, o_pc_target={target[31:2],2'b00}, all in the same cycle, combinationally.
  - clear o_inst_valid next edge.
  - a branch has priority over ack; an ack in the same cycle is dropped and causes no PC+4.
- Branch with o_imem_req=1 and no ack this cycle: latch the old i_pc into the discard-address register and go to DISCARD.
- DISCARD:
  - o_imem_req=1, o_imem_addr = latched old address.
  - on ack, drop the data and go to FETCH.
  - a further branch in DISCARD reloads the PC and stays in DISCARD.
- Branch in IDLE is ignored.

## Timing
- Reset values: state IDLE; o_inst_valid, o_inst, o_inst_pc, the discard address and the counters are 0; o_imem_req, o_pc_en and o_pc_load are 0.
- Zero-wait memory (ack in the request cycle): the instruction is visible on o_inst_valid the next cycle. Throughput is 1 instr/cycle with ready held high.
- First request is issued in the second cycle after rst deassertion, at address 0x0.
- Wait states: req and addr are held constant until ack. o_pc_en is asserted only in the ack cycle or a branch cycle.
- Redirect latency: the first request to the target is issued the cycle after the branch if no request was in flight. Otherwise it is issued the cycle after the discarded ack.
- rst mid-request: the state machine returns to IDLE immediately; the memory side must tolerate an abandoned request.

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - adds ports o_perf_fetched (PERF_W), counting buffer handoffs (valid && ready).
  - adds o_perf_flushed (PERF_W), counting branch cycles that flush the buffer or enter DISCARD.
  - both counters reset to 0, wrap at all-ones, and have no saturation.
- Not defined: the ports and counters are absent; no other behavioural difference.

## Structure
- Package fetch_pkg holds:
  - the state enum typedef (IDLE, FETCH, DISCARD);
  - INST_W=32;
  - the NOP/flush encoding constants, shared with decode.
- One sub-module, fetch_buf: the single-entry valid/ready register holding inst and inst_pc, with load, drain and flush inputs.
- The state machine, PC control and discard-address register live in fetch_ctrl.

## Test plan
- Reset, zero-wait memory, ready=1, rdata=addr^0xE000_0000:
  - expected addrs 0x0, 0x4, 0x8 on consecutive cycles;
  - o_inst_pc 0x0, 0x4, 0x8 one cycle later;
  - o_pc_en high every cycle.
- Ack delayed 2 cycles at PC 0x10: req and addr=0x10 held for 3 cycles, o_pc_en only in the third, then o_inst_pc=0x10.
- Backpressure: ready=0 while holding 0x4 → req drops to 0, buffer unchanged for 5 cycles; ready=1 → handoff, and a req at 0x8 is issued in the same cycle.
- Redirect with request at 0x8 pending: branch to 0x103 →
  - o_pc_load=1 with target 0x100;
  - DISCARD holds addr 0x8 until ack, data dropped, o_inst_valid=0;
  - next req is at 0x100.
- Branch to 0x200 coincident with the ack for 0xC → no buffer load, PC loads 0x200 (not 0x10), next addr 0x200. With FETCH_CTRL_PERF_EN, o_perf_flushed increments by 1.
- rst asserted during a wait state → all outputs 0 asynchronously; after release, fetch restarts at i_pc=0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction-fetch front end.
//
// Contents:
//   INST_W        instruction / fetch data width
//   NOP_INST      ARM "MOV r0, r0"; decode substitutes it for a flushed slot
//   FLUSH_INST    word decode presents while a redirect is flushing the pipe
//   fetch_state_e fetch sequencer states (IDLE, FETCH, DISCARD)
//   word_align()  clears the two byte-offset bits of an address
package fetch_pkg;

  localparam int INST_W = 32;

  localparam logic [31:0] NOP_INST   = 32'hE1A0_0000;
  localparam logic [31:0] FLUSH_INST = NOP_INST;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if -- bundle of every non-clock signal around the fetch sequencer.
//
// Groups:
//   PC register   : i_pc, o_pc_en, o_pc_load, o_pc_target
//   Instr memory  : o_imem_req, o_imem_addr, i_imem_ack, i_imem_rdata
//   Decode buffer : o_inst_valid, o_inst, o_inst_pc, i_inst_ready
//   Redirect      : i_branch_valid, i_branch_target
//
// Modports:
//   master -- the fetch sequencer (drives the o_* signals)
//   slave  -- the surrounding core / memory (drives the i_* signals)
interface fetch_ctrl_if #(
  parameter int DATA_W = 32
);

  logic [31:0]       i_pc;
  logic              o_pc_en;
  logic              o_pc_load;
  logic [31:0]       o_pc_target;

  logic              o_imem_req;
  logic [31:0]       o_imem_addr;
  logic              i_imem_ack;
  logic [DATA_W-1:0] i_imem_rdata;

  logic              o_inst_valid;
  logic [DATA_W-1:0] o_inst;
  logic [31:0]       o_inst_pc;
  logic              i_inst_ready;

  logic              i_branch_valid;
  logic [31:0]       i_branch_target;

  modport master (
    input  i_pc, i_imem_ack, i_imem_rdata, i_inst_ready,
           i_branch_valid, i_branch_target,
    output o_pc_en, o_pc_load, o_pc_target, o_imem_req, o_imem_addr,
           o_inst_valid, o_inst, o_inst_pc
  );

  modport slave (
    output i_pc, i_imem_ack, i_imem_rdata, i_inst_ready,
           i_branch_valid, i_branch_target,
    input  o_pc_en, o_pc_load, o_pc_target, o_imem_req, o_imem_addr,
           o_inst_valid, o_inst, o_inst_pc
  );

endinterface

// File: rtl/fetch_buf.sv
// fetch_buf -- single-entry valid/ready holding register between fetch and decode.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           capture load_inst / load_pc and mark the entry valid
//   load_inst      fetched instruction word
//   load_pc        address of load_inst
//   drain          decode is ready; a valid entry is handed off this cycle
//   flush          redirect in progress; discard the entry
//   valid          entry holds an instruction for decode
//   inst, inst_pc  held instruction and its address
//
// Priority is flush > load > drain: a load in the same cycle as a handoff
// refills the slot rather than leaving it empty.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_inst,
  input  logic [31:0]       load_pc,
  input  logic              drain,
  input  logic              flush,
  output logic              valid,
  output logic [DATA_W-1:0] inst,
  output logic [31:0]       inst_pc
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] inst_q,  inst_d;
  logic [31:0]       pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = load_inst;
      pc_d    = load_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid   = valid_q;
  assign inst    = inst_q;
  assign inst_pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencer for the ARMv4 front end.
//
// Keeps one instruction-memory request outstanding at the current PC, steps
// the PC register on each accepted response and hands words to decode through
// fetch_buf. A branch reloads the PC combinationally, flushes the buffer and,
// if a request is still in flight, parks in DISCARD until its response is
// swallowed.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       fetch_ctrl_if.master (PC control, imem, decode buffer, redirect)
//   o_perf_fetched  [PERF_W] buffer handoffs (valid && ready)   -- perf build only
//   o_perf_flushed  [PERF_W] redirect cycles outside IDLE        -- perf build only
//
// Build option:
//   FETCH_CTRL_PERF_EN  adds the two wrapping performance counters above.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int DATA_W = INST_W
`ifdef FETCH_CTRL_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  fetch_ctrl_if.master       bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  o_perf_fetched,
  output logic [PERF_W-1:0]  o_perf_flushed
`endif
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       disc_addr_q, disc_addr_d;

  logic              req;
  logic [31:0]       addr;
  logic              pc_en;
  logic              pc_load;
  logic [31:0]       pc_target;
  logic              branch;
  logic              buf_load;
  logic              buf_flush;

  logic              buf_valid;
  logic [DATA_W-1:0] buf_inst;
  logic [31:0]       buf_pc;

  // Next-state and output decode. A branch outranks a same-cycle ack: the
  // response is dropped and the PC takes the target instead of PC+4. When a
  // request is still waiting at redirect time its address is parked in
  // disc_addr so the memory sees a stable request until the stale ack lands.
  // In DISCARD the ack always returns to FETCH: even with a coincident branch
  // the in-flight response is the one being swallowed and the PC already holds
  // the newest target.
  always_comb begin
    state_d     = state_q;
    disc_addr_d = disc_addr_q;
    req         = 1'b0;
    addr        = '0;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    pc_target   = '0;
    branch      = 1'b0;
    buf_load    = 1'b0;
    buf_flush   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        req    = !buf_valid || bus.i_inst_ready;
        addr   = bus.i_pc;
        branch = bus.i_branch_valid;
        if (branch) begin
          if (req && !bus.i_imem_ack) begin
            disc_addr_d = bus.i_pc;
            state_d     = DISCARD;
          end
        end else if (req && bus.i_imem_ack) begin
          buf_load = 1'b1;
          pc_en    = 1'b1;
        end
      end
      DISCARD: begin
        req    = 1'b1;
        addr   = disc_addr_q;
        branch = bus.i_branch_valid;
        if (bus.i_imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (branch) begin
      pc_en     = 1'b1;
      pc_load   = 1'b1;
      pc_target = word_align(bus.i_branch_target);
      buf_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      disc_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      disc_addr_q <= disc_addr_d;
    end
  end

  fetch_buf #(
    .DATA_W (DATA_W)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_inst (bus.i_imem_rdata),
    .load_pc   (bus.i_pc),
    .drain     (bus.i_inst_ready),
    .flush     (buf_flush),
    .valid     (buf_valid),
    .inst      (buf_inst),
    .inst_pc   (buf_pc)
  );

  assign bus.o_imem_req   = req;
  assign bus.o_imem_addr  = addr;
  assign bus.o_pc_en      = pc_en;
  assign bus.o_pc_load    = pc_load;
  assign bus.o_pc_target  = pc_target;
  assign bus.o_inst_valid = buf_valid;
  assign bus.o_inst       = buf_inst;
  assign bus.o_inst_pc    = buf_pc;

`ifdef FETCH_CTRL_PERF_EN
  logic [PERF_W-1:0] fetched_q, fetched_d;
  logic [PERF_W-1:0] flushed_q, flushed_d;

  // Free-running event counters; they wrap through zero on overflow.
  always_comb begin
    fetched_d = fetched_q;
    flushed_d = flushed_q;
    if (buf_valid && bus.i_inst_ready) begin
      fetched_d = fetched_q + PERF_W'(1);
    end
    if (branch) begin
      flushed_d = flushed_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign o_perf_fetched = fetched_q;
  assign o_perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl.
//
// The bench plays the PC register and a variable-latency instruction memory
// (word at A reads as A ^ 0xE000_0000) and predicts every output from a
// queue-based reference model. Build option FETCH_CTRL_PERF_EN also checks
// the performance counters.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.DATA_W(32)) bus ();

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_ctrl #(
    .DATA_W (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .o_perf_fetched (perf_fetched),
    .o_perf_flushed (perf_flushed)
`endif
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  int unsigned assert_cnt = 0;
  int unsigned fail_cnt   = 0;

  // Environment: PC register and memory latency bookkeeping.
  logic [31:0] env_pc;
  int unsigned mem_wait;
  int unsigned mem_lat;
  int unsigned lat_min;
  int unsigned lat_max;
  bit          spurious_en;

  // Reference model: a started flag, a pending stale response and the
  // decode-side holding slot as a queue of at most one entry.
  bit          m_running;
  bit          m_discarding;
  logic [31:0] m_disc_addr;
  entry_t      hold_q[$];
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned newLat();
    return $urandom_range(lat_max, lat_min);
  endfunction

  task automatic modelReset();
    m_running    = 1'b0;
    m_discarding = 1'b0;
    m_disc_addr  = '0;
    hold_q.delete();
    m_fetched    = '0;
    m_flushed    = '0;
    env_pc       = '0;
    mem_wait     = 0;
    mem_lat      = newLat();
  endtask

  // One clock cycle: called just after a falling edge, drives inputs, checks
  // every output against the model, advances model and environment, and
  // returns at the next falling edge.
  task automatic applyStimulus(input bit ready, input bit br, input logic [31:0] tgt);
    bit          e_req, e_pcen, took, handoff;
    logic [31:0] e_addr, e_tgt, pc_now;
    entry_t      e;

    pc_now                = env_pc;
    bus.i_pc              = env_pc;
    bus.i_inst_ready      = ready;
    bus.i_branch_valid    = br;
    bus.i_branch_target   = tgt;
    bus.i_imem_ack        = 1'b0;
    bus.i_imem_rdata      = $urandom;
    #1;
    if (bus.o_imem_req === 1'b1 && mem_wait >= mem_lat) begin
      bus.i_imem_ack   = 1'b1;
      bus.i_imem_rdata = bus.o_imem_addr ^ 32'hE000_0000;
    end else if (bus.o_imem_req !== 1'b1 && spurious_en && $urandom_range(3) == 0) begin
      bus.i_imem_ack = 1'b1;
    end
    #1;

    if (!m_running) begin
      e_req  = 1'b0;
      e_addr = '0;
      e_pcen = 1'b0;
      took   = 1'b0;
    end else begin
      e_req  = m_discarding || hold_q.size() == 0 || ready;
      e_addr = m_discarding ? m_disc_addr : pc_now;
      took   = e_req && bus.i_imem_ack;
      e_pcen = br || (took && !m_discarding);
    end
    e_tgt = {tgt[31:2], 2'b00};

    checkOutput("imem_req", bus.o_imem_req, e_req);
    if (e_req || !m_running) checkOutput("imem_addr", bus.o_imem_addr, e_addr);
    checkOutput("pc_en", bus.o_pc_en, e_pcen);
    checkOutput("pc_load", bus.o_pc_load, m_running && br);
    if (m_running && br) checkOutput("pc_target", bus.o_pc_target, e_tgt);
    if (!m_running) checkOutput("pc_target_idle", bus.o_pc_target, 32'h0);
    checkOutput("inst_valid", bus.o_inst_valid, hold_q.size() != 0);
    if (hold_q.size() != 0) begin
      checkOutput("inst", bus.o_inst, hold_q[0].inst);
      checkOutput("inst_pc", bus.o_inst_pc, hold_q[0].pc);
    end
`ifdef FETCH_CTRL_PERF_EN
    checkOutput("perf_fetched", perf_fetched, m_fetched);
    checkOutput("perf_flushed", perf_flushed, m_flushed);
`endif

    // Reference model update.
    if (!m_running) begin
      m_running = 1'b1;
    end else begin
      handoff = hold_q.size() != 0 && ready;
      if (handoff) m_fetched++;
      if (br) begin
        m_flushed++;
        hold_q.delete();
        if (m_discarding) begin
          if (took) m_discarding = 1'b0;
        end else if (e_req && !bus.i_imem_ack) begin
          m_discarding = 1'b1;
          m_disc_addr  = pc_now;
        end
      end else if (m_discarding) begin
        if (took) m_discarding = 1'b0;
      end else begin
        if (handoff) void'(hold_q.pop_front());
        if (took) begin
          e.inst = pc_now ^ 32'hE000_0000;
          e.pc   = pc_now;
          hold_q.push_back(e);
        end
      end
    end

    // Environment update reacts to what the DUT actually drove.
    if (bus.o_imem_req === 1'b1) begin
      if (bus.i_imem_ack) begin
        mem_wait = 0;
        mem_lat  = newLat();
      end else begin
        mem_wait++;
      end
    end
    if (bus.o_pc_en === 1'b1) begin
      env_pc = (bus.o_pc_load === 1'b1) ? bus.o_pc_target : env_pc + 32'd4;
    end

    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"}, bus.o_imem_req, 32'h0);
    checkOutput({tag, "_addr"}, bus.o_imem_addr, 32'h0);
    checkOutput({tag, "_pc_en"}, bus.o_pc_en, 32'h0);
    checkOutput({tag, "_pc_load"}, bus.o_pc_load, 32'h0);
    checkOutput({tag, "_valid"}, bus.o_inst_valid, 32'h0);
    checkOutput({tag, "_inst"}, bus.o_inst, 32'h0);
    checkOutput({tag, "_inst_pc"}, bus.o_inst_pc, 32'h0);
  endtask

  task automatic setLatency(input int unsigned lo, input int unsigned hi);
    lat_min = lo;
    lat_max = hi;
    mem_lat = newLat();
  endtask

  initial begin
    bit seen;

    rst                 = 1'b1;
    bus.i_pc            = '0;
    bus.i_inst_ready    = 1'b0;
    bus.i_branch_valid  = 1'b0;
    bus.i_branch_target = '0;
    bus.i_imem_ack      = 1'b0;
    bus.i_imem_rdata    = '0;
    spurious_en         = 1'b0;
    lat_min             = 0;
    lat_max             = 0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] zero-wait streaming");
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("[TB] two wait states per request");
    setLatency(2, 2);
    repeat (9) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("[TB] decode backpressure");
    setLatency(0, 0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("[TB] redirect with a request in flight");
    setLatency(2, 2);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    repeat (7) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("[TB] redirect coincident with an ack");
    setLatency(0, 0);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

    $display("[TB] randomized traffic");
    setLatency(0, 3);
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(3) != 0, $urandom_range(11) == 0, $urandom & 32'h0000_0FFF);
    end

    $display("[TB] reset during a wait state");
    spurious_en = 1'b0;
    setLatency(3, 3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (bus.o_imem_req === 1'b1 && mem_wait > 0) seen = 1'b1;
    end
    checkOutput("wait_state_seen", seen, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    bus.i_imem_ack     = 1'b0;
    bus.i_branch_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    setLatency(0, 0);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);

    setLatency(0, 2);
    spurious_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(1) != 0, $urandom_range(7) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
